// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's pipeline-facing signals.
//   Control in : stall, br_taken/br_target, j_taken/j_target
//   IMEM       : imem_addr (out of the stage), imem_rdata (into the stage)
//   IF/ID      : pc, ifid_instr, ifid_pc4, ifid_valid (out of the stage)
// Modports:
//   master - the surrounding CPU (hazard unit, ID, EX/MEM, instruction memory)
//   slave  - the fetch stage itself
interface if_stage_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        j_taken;
    logic [31:0] j_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    modport master (
        output stall, br_taken, br_target, j_taken, j_target, imem_rdata,
        input  imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid
    );

    modport slave (
        input  stall, br_taken, br_target, j_taken, j_target, imem_rdata,
        output imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC (sequential,
// taken-BEQ redirect, J redirect), drives the instruction-memory address
// combinationally from the PC and registers the fetched word into IF/ID.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   bus        - if_stage_if.slave (control, IMEM read, IF/ID outputs)
//   stall_cnt, flush_cnt, fetch_cnt - performance counters, present only
//                when IF_PERF_CNT_EN is defined
//
// Optional feature macro: IF_PERF_CNT_EN
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.slave   bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] fetch_cnt
`endif
);

    logic [31:0] pc_reg;
    logic [31:0] ifid_instr_reg;
    logic [31:0] ifid_pc4_reg;
    logic        ifid_valid_reg;
    logic [31:0] pc4;

    // 32-bit modulo increment: 0xFFFF_FFFC wraps to 0.
    assign pc4 = pc_reg + 32'd4;

    // Priority: taken BEQ > stall > J > sequential. The BEQ wins over a stall
    // because the stalled instruction is younger than the branch and dies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg         <= RESET_PC;
            ifid_instr_reg <= NOP_INSTR;
            ifid_pc4_reg   <= 32'd0;
            ifid_valid_reg <= 1'b0;
        end else if (bus.br_taken) begin
            pc_reg         <= {bus.br_target[31:2], 2'b00};
            ifid_instr_reg <= NOP_INSTR;
            ifid_pc4_reg   <= 32'd0;
            ifid_valid_reg <= 1'b0;
        end else if (bus.stall) begin
            // Hold everything; a concurrent J is re-asserted by ID later.
            pc_reg         <= pc_reg;
            ifid_instr_reg <= ifid_instr_reg;
            ifid_pc4_reg   <= ifid_pc4_reg;
            ifid_valid_reg <= ifid_valid_reg;
        end else if (bus.j_taken) begin
            pc_reg         <= {bus.j_target[31:2], 2'b00};
            ifid_instr_reg <= NOP_INSTR;
            ifid_pc4_reg   <= 32'd0;
            ifid_valid_reg <= 1'b0;
        end else begin
            pc_reg         <= pc4;
            ifid_instr_reg <= bus.imem_rdata;
            ifid_pc4_reg   <= pc4;
            ifid_valid_reg <= 1'b1;
        end
    end

    assign bus.imem_addr  = pc_reg;
    assign bus.pc         = pc_reg;
    assign bus.ifid_instr = ifid_instr_reg;
    assign bus.ifid_pc4   = ifid_pc4_reg;
    assign bus.ifid_valid = ifid_valid_reg;

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;
    logic [31:0] fetch_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
            fetch_cnt_reg <= 32'd0;
        end else begin
            if (bus.stall && !bus.br_taken)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (bus.br_taken || (bus.j_taken && !bus.stall))
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            if (!bus.br_taken && !bus.stall && !bus.j_taken)
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
    assign fetch_cnt = fetch_cnt_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal
// expectations followed by randomized control traffic, all compared every
// cycle against a behavioural model of the fetch rules.
module tb_if_stage;
    logic clk;
    logic rst;
    logic check_en;
    int   checks;
    int   fails;

    if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, fetch_cnt;
`endif

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .fetch_cnt (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0020;
        if (a == 32'h4) return 32'h8C01_0004;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: what IF/ID and the PC must be after each edge.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [31:0] m_stall, m_flush, m_fetch;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            m_stall <= 0; m_flush <= 0; m_fetch <= 0;
        end else begin
            if (bus.br_taken) begin
                m_pc <= bus.br_target & ~32'h3;
                m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
                m_flush <= m_flush + 1;
            end else if (bus.stall) begin
                m_stall <= m_stall + 1;
            end else if (bus.j_taken) begin
                m_pc <= bus.j_target & ~32'h3;
                m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
                m_flush <= m_flush + 1;
            end else begin
                m_pc <= m_pc + 32'd4;
                m_instr <= mem_word(m_pc);
                m_pc4 <= m_pc + 32'd4;
                m_valid <= 1'b1;
                m_fetch <= m_fetch + 1;
            end
        end
    end

    // Compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (check_en && rst) begin
            check32("pc", bus.pc, m_pc);
            check32("imem_addr", bus.imem_addr, m_pc);
            check32("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, m_valid});
            check32("ifid_instr", bus.ifid_instr, m_instr);
            if (m_valid) check32("ifid_pc4", bus.ifid_pc4, m_pc4);
`ifdef IF_PERF_CNT_EN
            check32("stall_cnt", stall_cnt, m_stall);
            check32("flush_cnt", flush_cnt, m_flush);
            check32("fetch_cnt", fetch_cnt, m_fetch);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 1'b0; bus.br_taken = 1'b0; bus.j_taken = 1'b0;
        bus.br_target = 32'h0; bus.j_target = 32'h0;
    endtask

    initial begin
        checks = 0; fails = 0; check_en = 1'b0;
        // Controls asserted during reset must be ignored.
        rst = 1'b0;
        bus.stall = 1'b1; bus.br_taken = 1'b1; bus.j_taken = 1'b1;
        bus.br_target = 32'h100; bus.j_target = 32'h200;
        #2;
        check32("rst_pc", bus.pc, 32'h0);
        check32("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check32("rst_instr", bus.ifid_instr, 32'h0);
        check32("rst_pc4", bus.ifid_pc4, 32'h0);
        #5; // past the edge at 5 with reset held
        check32("rst_hold_pc", bus.pc, 32'h0);
        idle();
        #5;
        rst = 1'b1; // at 12, between edges
        check_en = 1'b1;

        // Sequential fetch from reset
        step();
        check32("t1_pc", bus.pc, 32'h4);
        check32("t1_instr", bus.ifid_instr, 32'h0000_0020);
        check32("t1_pc4", bus.ifid_pc4, 32'h4);
        check32("t1_valid", {31'd0, bus.ifid_valid}, 32'd1);
        step();
        check32("t1b_pc", bus.pc, 32'h8);
        check32("t1b_instr", bus.ifid_instr, 32'h8C01_0004);

        // Three-cycle stall at pc=8
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check32("t2_pc_hold", bus.pc, 32'h8);
            check32("t2_instr_hold", bus.ifid_instr, 32'h8C01_0004);
        end
        bus.stall = 1'b0;
        step();
        check32("t2_pc", bus.pc, 32'hC);
        check32("t2_instr", bus.ifid_instr, mem_word(32'h8));
        check32("t2_pc4", bus.ifid_pc4, 32'hC);

        // J redirect
        bus.j_taken = 1'b1; bus.j_target = 32'h40;
        step();
        check32("t3_pc", bus.pc, 32'h40);
        check32("t3_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check32("t3_instr", bus.ifid_instr, 32'h0);
        idle();
        step();
        check32("t3b_instr", bus.ifid_instr, mem_word(32'h40));
        check32("t3b_pc4", bus.ifid_pc4, 32'h44);

        // BEQ beats stall and J; target aligned
        bus.br_taken = 1'b1; bus.br_target = 32'h22;
        bus.stall = 1'b1; bus.j_taken = 1'b1; bus.j_target = 32'h80;
        step();
        check32("t4_pc", bus.pc, 32'h20);
        check32("t4_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check32("t4_pc4", bus.ifid_pc4, 32'h0);
        idle();

        // Wrap at top of address space, then async reset mid-cycle
        bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
        step();
        idle();
        check32("t5_pc_top", bus.pc, 32'hFFFF_FFFC);
        step();
        check32("t5_wrap_pc", bus.pc, 32'h0);
        check32("t5_wrap_pc4", bus.ifid_pc4, 32'h0);
        check32("t5_wrap_instr", bus.ifid_instr, mem_word(32'hFFFF_FFFC));
        step();
        check32("t5_pc4_addr", bus.pc, 32'h4);
        #3;
        rst = 1'b0;
        #2;
        check32("t5_async_pc", bus.pc, 32'h0);
        check32("t5_async_valid", {31'd0, bus.ifid_valid}, 32'd0);
        step();
        check32("t5_held_pc", bus.pc, 32'h0);
        rst = 1'b1;

`ifdef IF_PERF_CNT_EN
        check32("t6_rst_fetch", fetch_cnt, 32'd0);
        for (int i = 0; i < 5; i++) step();
        bus.stall = 1'b1; step(); step(); idle();
        bus.j_taken = 1'b1; bus.j_target = 32'h100; step(); idle();
        bus.br_taken = 1'b1; bus.br_target = 32'h200; step(); idle();
        check32("t6_stall_cnt", stall_cnt, 32'd2);
        check32("t6_flush_cnt", flush_cnt, 32'd2);
        check32("t6_fetch_cnt", fetch_cnt, 32'd5);
`endif

        // Randomized control traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.br_taken  = ($urandom_range(0, 9) == 0);
            bus.j_taken   = ($urandom_range(0, 7) == 0);
            bus.stall     = ($urandom_range(0, 4) == 0);
            bus.br_target = $urandom;
            bus.j_target  = $urandom;
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
